// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types for the MINAv2 memory stage.
//   mem_op_t    - memory operation encoding carried from EX
//   lsu_state_t - load/store unit transaction state
//   helpers     - load/store classification and alignment check
package mem_lsu_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // Width of the REQ wait counter.
  localparam int unsigned TO_CNT_W = 8;

  function automatic logic op_is_load(input mem_op_t op);
    logic res;
    res = op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    return res;
  endfunction

  function automatic logic op_is_store(input mem_op_t op);
    logic res;
    res = op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
    return res;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] offset);
    logic res;
    res = 1'b0;
    case (op)
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: res = offset[0];
      MEM_OP_LW, MEM_OP_SW:             res = (offset != 2'b00);
      default:                          res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   op_i, offset_i - operation and byte offset within the word
//   st_data_i      - right-justified store data
//   rdata_i        - raw bus read word
//   be_o           - byte enables for the access (bit n = lane n)
//   wdata_o        - store data replicated onto the lanes
//   ld_data_o      - selected and sign/zero-extended load result
module lsu_align
  import mem_lsu_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  rd_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = rdata_i[8*gi +: 8];
    // Each lane carries the byte that lands there for the access size:
    // byte stores replicate byte 0, halfword stores replicate the low half.
    assign wdata_o[8*gi +: 8] =
        (op_i == MEM_OP_SB) ? st_data_i[7:0] :
        (op_i == MEM_OP_SH) ? st_data_i[8*(gi%2) +: 8] :
        (op_i == MEM_OP_SW) ? st_data_i[8*gi +: 8] : 8'h00;
  end

  always_comb begin
    ld_byte   = rd_lane[offset_i];
    ld_half   = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_o      = 4'b0000;
    ld_data_o = 32'h0000_0000;

    case (op_i)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: be_o = 4'b0001 << offset_i;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: be_o = offset_i[1] ? 4'b1100 : 4'b0011;
      MEM_OP_LW, MEM_OP_SW:             be_o = 4'b1111;
      default:                          be_o = 4'b0000;
    endcase

    case (op_i)
      MEM_OP_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_OP_LBU: ld_data_o = {24'h000000, ld_byte};
      MEM_OP_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEM_OP_LHU: ld_data_o = {16'h0000, ld_half};
      MEM_OP_LW:  ld_data_o = rdata_i;
      default:    ld_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit of the MINAv2 memory stage.
// Takes one memory op from EX, runs a single req/ack transaction on the
// data bus and returns aligned, extended load data for write-back.
//   clk, rst_n                 - clock, synchronous active-low reset
//   in_valid, mem_op, addr,
//   st_data, rd_addr           - request from EX
//   stall                      - hold upstream pipeline registers
//   wb_valid, wb_rd_addr,
//   wb_data                    - load write-back (one-cycle pulse)
//   fault                      - misaligned access pulse
//   bus_err                    - bus timeout pulse
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata          - registered bus request
//   bus_ack, bus_rdata         - bus completion and read data
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255  // 0 disables the timeout
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  mem_op_t     mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic                TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value during the last REQ cycle allowed before timing out.
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t          state_q, state_d;
  mem_op_t             op_q, op_d;
  logic [1:0]          off_q, off_d;
  logic [4:0]          rd_q, rd_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic        bus_err_q, bus_err_d;

  logic        req_present;
  logic        req_misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [31:0] st_ld_unused;
  logic [3:0]  ld_be_unused;
  logic [31:0] ld_wdata_unused;

  // Store path: lanes and enables from the incoming request.
  lsu_align u_align_st (
    .op_i      (mem_op),
    .offset_i  (addr[1:0]),
    .st_data_i (st_data),
    .rdata_i   (32'h0000_0000),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_data_o (st_ld_unused)
  );

  // Load path: extraction from the bus word using the latched op/offset.
  lsu_align u_align_ld (
    .op_i      (op_q),
    .offset_i  (off_q),
    .st_data_i (32'h0000_0000),
    .rdata_i   (bus_rdata),
    .be_o      (ld_be_unused),
    .wdata_o   (ld_wdata_unused),
    .ld_data_o (ld_data)
  );

  // No request is taken while reset is asserted, which keeps stall low then.
  assign req_present    = rst_n && in_valid && (mem_op != MEM_OP_NONE);
  assign req_misaligned = op_misaligned(mem_op, addr[1:0]);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    fault_d     = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      LSU_IDLE: begin
        if (req_present) begin
          if (req_misaligned) begin
            // Rejected without touching the bus; pipeline is not held.
            fault_d = 1'b1;
          end else begin
            stall       = 1'b1;
            op_d        = mem_op;
            off_d       = addr[1:0];
            rd_d        = rd_addr;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = op_is_store(mem_op);
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = op_is_store(mem_op) ? st_wdata : 32'h0000_0000;
            state_d     = LSU_REQ;
          end
        end
      end

      LSU_REQ: begin
        stall = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (op_is_load(op_q)) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ld_data;
            wb_rd_d    = rd_q;
          end
          state_d = LSU_RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = LSU_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LSU_RESP: begin
        // wb_valid is already high from the ack edge; requests wait a cycle.
        state_d = LSU_IDLE;
      end

      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      op_q        <= MEM_OP_NONE;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0000_0000;
      fault_q     <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd_addr = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu (timeout limit 4 cycles).
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  mem_op_t     mem_op;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic [4:0]  rd_addr;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        fault;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mem_op     (mem_op),
    .addr       (addr),
    .st_data    (st_data),
    .rd_addr    (rd_addr),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .fault      (fault),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access: inputs plus expected results. dly >= TO means no ack (timeout).
  typedef struct {
    mem_op_t     op;
    logic [31:0] addr;
    logic [31:0] st;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] rdata;
    bit          exp_fault;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t vec(input mem_op_t op, input logic [31:0] a, input logic [31:0] st,
                               input logic [4:0] rd, input int dly, input logic [31:0] rdata,
                               input bit f, input logic [3:0] be, input logic [31:0] wd,
                               input logic [31:0] wb);
    vec_t v;
    v.op = op; v.addr = a; v.st = st; v.rd = rd; v.dly = dly; v.rdata = rdata;
    v.exp_fault = f; v.exp_be = be; v.exp_wdata = wd; v.exp_wb = wb;
    return v;
  endfunction

  // Reference model: access size, lane position and extension by arithmetic.
  function automatic vec_t model(input mem_op_t op, input logic [31:0] a, input logic [31:0] st,
                                 input logic [4:0] rd, input int dly, input logic [31:0] rdata);
    vec_t v;
    int size;
    int off;
    bit sgn;
    logic [63:0] mask;
    logic [31:0] val;
    v.op = op; v.addr = a; v.st = st; v.rd = rd; v.dly = dly; v.rdata = rdata;
    size = (op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB}) ? 1 :
           (op inside {MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH}) ? 2 : 4;
    sgn  = op inside {MEM_OP_LB, MEM_OP_LH};
    off  = int'(a % 4);
    v.exp_fault = (off % size) != 0;
    v.exp_be    = 4'(((1 << size) - 1) << off);
    if (size == 1)      v.exp_wdata = {24'h0, st[7:0]} * 32'h0101_0101;
    else if (size == 2) v.exp_wdata = {16'h0, st[15:0]} * 32'h0001_0001;
    else                v.exp_wdata = st;
    mask = (64'd1 << (8 * size)) - 64'd1;
    val  = 32'(({32'h0, rdata} >> (8 * off)) & mask);
    if (sgn && val[8*size-1]) val = val | ~mask[31:0];
    v.exp_wb = val;
    return v;
  endfunction

  // A request that must be ignored because the unit is busy.
  task automatic drive_noise();
    in_valid = 1'b1;
    mem_op   = mem_op_t'($urandom_range(0, 8));
    addr     = $urandom;
    st_data  = $urandom;
    rd_addr  = 5'($urandom);
  endtask

  // Starts #1 after a rising edge with the unit idle; returns in the same phase.
  task automatic run_vec(input vec_t v, input bit noise, input int idx);
    int stall_cnt;
    int exp_stall;
    bit is_ld;
    bit acked;
    stall_cnt = 0;
    is_ld = v.op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
    acked = v.dly < TO;
    $display("[TB] txn %0d %s addr=%h st=%h rd=%0d dly=%0d rdata=%h", idx, v.op.name(),
             v.addr, v.st, v.rd, v.dly, v.rdata);

    in_valid = 1'b1; mem_op = v.op; addr = v.addr; st_data = v.st; rd_addr = v.rd;
    bus_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_rdata = $urandom;
    @(negedge clk);
    stall_cnt += int'(stall);
    chk1("c0_stall", stall, !v.exp_fault);
    chk1("c0_fault", fault, 1'b0);
    chk1("c0_bus_req", bus_req, 1'b0);
    chk1("c0_wb_valid", wb_valid, 1'b0);
    chk1("c0_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = MEM_OP_NONE; bus_ack = 1'b0;

    if (v.exp_fault) begin
      @(negedge clk);
      stall_cnt += int'(stall);
      chk1("mis_fault", fault, 1'b1);
      chk1("mis_bus_req", bus_req, 1'b0);
      chk1("mis_wb_valid", wb_valid, 1'b0);
      @(posedge clk); #1;
      exp_stall = 0;
    end else begin
      for (int k = 0; k < TO; k++) begin
        if (noise) drive_noise();
        if (k == v.dly) begin
          bus_ack = 1'b1; bus_rdata = v.rdata;
        end else begin
          bus_rdata = $urandom;
        end
        @(negedge clk);
        stall_cnt += int'(stall);
        chk1("req_stall", stall, 1'b1);
        chk1("req_bus_req", bus_req, 1'b1);
        chk1("req_bus_we", bus_we, !is_ld);
        chk32("req_bus_addr", bus_addr, v.addr & 32'hFFFF_FFFC);
        chk1("req_wb_valid", wb_valid, 1'b0);
        chk1("req_bus_err", bus_err, 1'b0);
        chk1("req_fault", fault, 1'b0);
        if (!is_ld) begin
          chk32("req_bus_be", 32'(bus_be), 32'(v.exp_be));
          chk32("req_bus_wdata", bus_wdata, v.exp_wdata);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0; in_valid = 1'b0; mem_op = MEM_OP_NONE;
        if (k == v.dly) break;
      end
      if (acked) begin
        if (noise) begin
          drive_noise();
          bus_ack = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        stall_cnt += int'(stall);
        chk1("resp_wb_valid", wb_valid, is_ld);
        if (is_ld) begin
          chk32("resp_wb_data", wb_data, v.exp_wb);
          chk32("resp_wb_rd", 32'(wb_rd_addr), 32'(v.rd));
        end
        chk1("resp_bus_req", bus_req, 1'b0);
        chk1("resp_stall", stall, 1'b0);
        chk1("resp_bus_err", bus_err, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; mem_op = MEM_OP_NONE; bus_ack = 1'b0;
        exp_stall = v.dly + 2;
      end else begin
        @(negedge clk);
        stall_cnt += int'(stall);
        chk1("to_bus_err", bus_err, 1'b1);
        chk1("to_bus_req", bus_req, 1'b0);
        chk1("to_wb_valid", wb_valid, 1'b0);
        @(posedge clk); #1;
        exp_stall = TO + 1;
      end
    end
    chk32("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;

    // Byte 2 of 0x0080FF00 is 0x80, so LB there sign-extends.
    tbl.push_back(vec(MEM_OP_SW,  32'h100, 32'hDEADBEEF, 5'd1,  0, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0));
    tbl.push_back(vec(MEM_OP_SB,  32'h103, 32'h000000A5, 5'd2,  0, 32'h0,        0, 4'b1000, 32'hA5A5A5A5, 32'h0));
    tbl.push_back(vec(MEM_OP_LB,  32'h102, 32'h0,        5'd3,  3, 32'h0080FF00, 0, 4'b0100, 32'h0,        32'hFFFFFF80));
    tbl.push_back(vec(MEM_OP_LH,  32'h102, 32'h0,        5'd4,  1, 32'h0080FF00, 0, 4'b1100, 32'h0,        32'h00000080));
    tbl.push_back(vec(MEM_OP_LHU, 32'h100, 32'h0,        5'd5,  2, 32'h0080FF00, 0, 4'b0011, 32'h0,        32'h0000FF00));
    tbl.push_back(vec(MEM_OP_LB,  32'h101, 32'h0,        5'd6,  0, 32'h0080FF00, 0, 4'b0010, 32'h0,        32'hFFFFFFFF));
    tbl.push_back(vec(MEM_OP_LW,  32'h102, 32'h0,        5'd8,  0, 32'h0,        1, 4'b0000, 32'h0,        32'h0));
    tbl.push_back(vec(MEM_OP_LW,  32'h104, 32'h0,        5'd9,  4, 32'h0,        0, 4'b1111, 32'h0,        32'h0));
    tbl.push_back(vec(MEM_OP_SH,  32'h106, 32'h1234ABCD, 5'd10, 2, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0));
    tbl.push_back(vec(MEM_OP_SH,  32'h105, 32'h1234ABCD, 5'd11, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0));
    tbl.push_back(vec(MEM_OP_LBU, 32'h103, 32'h0,        5'd12, 1, 32'h80000000, 0, 4'b1000, 32'h0,        32'h00000080));
    tbl.push_back(vec(MEM_OP_LW,  32'h108, 32'h0,        5'd31, 3, 32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678));
    tbl.push_back(vec(MEM_OP_SB,  32'h101, 32'hFFFFFF3C, 5'd13, 4, 32'h0,        0, 4'b0010, 32'h3C3C3C3C, 32'h0));
    tbl.push_back(vec(MEM_OP_LH,  32'h100, 32'h0,        5'd14, 0, 32'h00008001, 0, 4'b0011, 32'h0,        32'hFFFF8001));
    tbl.push_back(vec(MEM_OP_SW,  32'h10A, 32'h0,        5'd15, 0, 32'h0,        1, 4'b0000, 32'h0,        32'h0));

    // Reset with a request pending: nothing may be accepted or driven.
    rst_n = 1'b0; in_valid = 1'b1; mem_op = MEM_OP_LW; addr = 32'h40;
    st_data = 32'h0; rd_addr = 5'd1; bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_bus_req", bus_req, 1'b0);
    chk1("rst_bus_we", bus_we, 1'b0);
    chk32("rst_bus_addr", bus_addr, 32'h0);
    chk32("rst_bus_be", 32'(bus_be), 32'h0);
    chk32("rst_bus_wdata", bus_wdata, 32'h0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk32("rst_wb_rd", 32'(wb_rd_addr), 32'h0);
    chk32("rst_wb_data", wb_data, 32'h0);
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; mem_op = MEM_OP_NONE;

    foreach (tbl[i]) run_vec(tbl[i], 1'b0, i);

    // Reset while in REQ, with an ack arriving in the reset cycle.
    $display("[TB] txn reset-during-REQ LW addr=00000300");
    in_valid = 1'b1; mem_op = MEM_OP_LW; addr = 32'h300; rd_addr = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; mem_op = MEM_OP_NONE;
    @(negedge clk);
    chk1("rq_bus_req_pre", bus_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    chk1("rq_bus_req_held", bus_req, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1; bus_ack = 1'b0;
    @(negedge clk);
    chk1("rq_bus_req_post", bus_req, 1'b0);
    chk1("rq_stall_post", stall, 1'b0);
    for (int c = 0; c < 6; c++) begin
      chk1("rq_wb_valid", wb_valid, 1'b0);
      chk1("rq_bus_err", bus_err, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    run_vec(vec(MEM_OP_LW, 32'h200, 32'h0, 5'd7, 0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 32'hCAFEF00D),
            1'b0, 100);

    // Randomized accesses with busy-time noise on the request and ack inputs.
    for (int i = 0; i < 60; i++) begin
      v = model(mem_op_t'($urandom_range(1, 8)), $urandom, $urandom, 5'($urandom),
                int'($urandom_range(0, TO)), $urandom);
      run_vec(v, 1'b1, 200 + i);
    end

    @(negedge clk);
    chk1("end_stall", stall, 1'b0);
    chk1("end_bus_req", bus_req, 1'b0);
    chk1("end_wb_valid", wb_valid, 1'b0);
    chk1("end_bus_err", bus_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
